// File: rtl/output_module.sv
// Router output port: round-robin arbitration over four input buffers with
// wormhole locking, credit-based flow control and a registered link flit.
module output_module #(
  parameter int  DATA_WIDTH = 32,
  parameter int  BUF_DEPTH  = 4,
  localparam int CW         = $clog2(BUF_DEPTH + 1)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [3:0]              in_valid,
  input  logic [4*DATA_WIDTH-1:0] in_data,
  output logic [3:0]              in_grant,
  output logic                    out_valid,
  output logic [DATA_WIDTH-1:0]   out_data,
  input  logic                    credit_in,
  output logic [CW-1:0]           credits,
  output logic [1:0]              owner,
  output logic                    locked,
  output logic                    error
);

  typedef enum logic {IDLE, LOCKED} state_t;

  typedef enum logic [1:0] {
    FT_HEAD   = 2'b00,
    FT_BODY   = 2'b01,
    FT_TAIL   = 2'b10,
    FT_SINGLE = 2'b11
  } flit_t;

  localparam logic [CW-1:0] CREDIT_MAX = CW'(BUF_DEPTH);

  state_t                  state, state_nx;
  logic   [1:0]            rr_ptr, rr_nx, owner_nx;
  logic   [1:0]            sel, idx;
  logic                    found, viol, can_send;
  logic   [3:0]            grant;
  logic   [DATA_WIDTH-1:0] sel_flit;
  flit_t                   ftype [4];

  always_comb begin
    for (int i = 0; i < 4; i++)
      ftype[i] = flit_t'(in_data[i*DATA_WIDTH + DATA_WIDTH-2 +: 2]);
  end

  assign can_send = (credits != '0);

  // NOTE: every variable written here gets a default first, so no path
  // through the block leaves one unassigned and a latch is never inferred.
  always_comb begin
    state_nx = state;
    rr_nx    = rr_ptr;
    owner_nx = owner;
    grant    = '0;
    viol     = 1'b0;
    found    = 1'b0;
    sel      = owner;
    idx      = rr_ptr;

    unique case (state)
      IDLE: begin
        for (int i = 0; i < 4; i++) begin
          idx = rr_ptr + 2'(i);
          if (!found && in_valid[idx] &&
              (ftype[idx] == FT_HEAD || ftype[idx] == FT_SINGLE)) begin
            found = 1'b1;
            sel   = idx;
          end
          // A body/tail with no packet open is a framing error; it is left in place.
          if (in_valid[i] && (ftype[i] == FT_BODY || ftype[i] == FT_TAIL))
            viol = 1'b1;
        end
        if (found && can_send) begin
          grant[sel] = 1'b1;
          if (ftype[sel] == FT_HEAD) begin
            state_nx = LOCKED;
            owner_nx = sel;
          end else begin
            rr_nx = sel + 2'd1;
          end
        end
      end
      LOCKED: begin
        if (in_valid[owner]) begin
          if (ftype[owner] == FT_BODY || ftype[owner] == FT_TAIL) begin
            if (can_send) begin
              grant[owner] = 1'b1;
              if (ftype[owner] == FT_TAIL) begin
                state_nx = IDLE;
                rr_nx    = owner + 2'd1;
              end
            end
          end else begin
            viol = 1'b1;
          end
        end
      end
      default: state_nx = IDLE;
    endcase

    // A returned credit with nothing outstanding would overflow the mirror.
    if (credit_in && !(|grant) && credits == CREDIT_MAX)
      viol = 1'b1;

    if (reset)
      grant = '0;
  end

  assign in_grant = grant;
  assign sel_flit = in_data[sel*DATA_WIDTH +: DATA_WIDTH];
  assign locked   = (state == LOCKED);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      owner     <= 2'd0;
      rr_ptr    <= 2'd0;
      credits   <= CREDIT_MAX;
      out_valid <= 1'b0;
      out_data  <= '0;
      error     <= 1'b0;
    end else begin
      state     <= state_nx;
      owner     <= owner_nx;
      rr_ptr    <= rr_nx;
      out_valid <= |grant;
      error     <= viol;
      if (|grant)
        out_data <= sel_flit;
      unique case ({|grant, credit_in})
        2'b10:   credits <= credits - CW'(1);
        2'b01:   if (credits != CREDIT_MAX) credits <= credits + CW'(1);
        default: credits <= credits;
      endcase
    end
  end

endmodule

// File: tb/tb_output_module.sv
// Directed bench for output_module: arbitration order, wormhole locking,
// credit exhaustion, protocol errors and reset mid-packet.
module tb_output_module;

  localparam int DW = 32;
  localparam logic [1:0] HD = 2'b00, BD = 2'b01, TL = 2'b10, SG = 2'b11;

  logic          clk = 1'b0;
  logic          reset;
  logic [3:0]    in_valid;
  logic [4*DW-1:0] in_data;
  logic [3:0]    in_grant;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          credit_in;
  logic [2:0]    credits;
  logic [1:0]    owner;
  logic          locked;
  logic          error;

  int checks = 0;
  int errors = 0;

  output_module #(.DATA_WIDTH(DW), .BUF_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_grant(in_grant), .out_valid(out_valid), .out_data(out_data),
    .credit_in(credit_in), .credits(credits), .owner(owner),
    .locked(locked), .error(error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] mk(input logic [1:0] ft, input logic [29:0] pl);
    return {ft, pl};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input int src, input logic [DW-1:0] f);
    in_data[src*DW +: DW] = f;
    in_valid[src] = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; in_valid = '0; in_data = '0; credit_in = 1'b0;
    tick(); tick();

    // Reset values and grant suppression under reset
    put(0, mk(SG, 30'h0AA));
    #1 check("grant_in_reset", in_grant, 4'b0000);
    tick();
    check("rst_locked", locked, 0);
    check("rst_owner", owner, 0);
    check("rst_credits", credits, 4);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_error", error, 0);

    // Single flit on N
    reset = 1'b0;
    #1 check("single_grant", in_grant, 4'b0001);
    tick();
    check("single_out_valid", out_valid, 1);
    check("single_out_data", out_data, mk(SG, 30'h0AA));
    check("single_credits", credits, 3);
    check("single_locked", locked, 0);
    in_valid = '0;
    credit_in = 1'b1;
    tick();
    check("refill_credits", credits, 4);
    check("refill_error", error, 0);

    // Round-robin: rr_ptr is 1 after N, so order S, E, W, N; credit_in held
    for (int k = 0; k < 4; k++) begin
      int src;
      for (int s = 0; s < 4; s++) put(s, mk(SG, 30'h100 + 30'(s)));
      src = (1 + k) % 4;
      #1 check("rr_grant", in_grant, 4'b0001 << src);
      tick();
      check("rr_out_data", out_data, mk(SG, 30'h100 + 30'(src)));
      check("rr_credits", credits, 4);
      check("rr_error", error, 0);
    end
    in_valid = '0;

    // Wormhole: S head/body/tail while E holds a head (credit_in still 1)
    put(1, mk(HD, 30'h201)); put(2, mk(HD, 30'h302));
    #1 check("wh_head_grant", in_grant, 4'b0010);
    tick();
    check("wh_locked", locked, 1);
    check("wh_owner", owner, 1);
    check("wh_head_data", out_data, mk(HD, 30'h201));
    put(1, mk(BD, 30'h211));
    #1 check("wh_body_grant", in_grant, 4'b0010);
    tick();
    check("wh_locked_body", locked, 1);
    check("wh_owner_body", owner, 1);
    put(1, mk(TL, 30'h221));
    #1 check("wh_tail_grant", in_grant, 4'b0010);
    tick();
    check("wh_unlocked", locked, 0);
    check("wh_tail_data", out_data, mk(TL, 30'h221));
    check("wh_error", error, 0);
    in_valid[1] = 1'b0;
    #1 check("wh_e_grant", in_grant, 4'b0100);
    tick();
    check("wh_e_owner", owner, 2);
    check("wh_e_credits", credits, 4);
    put(2, mk(TL, 30'h322));
    #1 check("wh_e_tail_grant", in_grant, 4'b0100);
    tick();
    check("wh_e_unlocked", locked, 0);
    in_valid = '0;
    credit_in = 1'b0;

    // Credit exhaustion: 6-flit packet on W, no returned credits
    put(3, mk(HD, 30'h400));
    #1 check("ce_head_grant", in_grant, 4'b1000);
    tick();
    check("ce_credits_3", credits, 3);
    for (int b = 1; b <= 3; b++) begin
      put(3, mk(BD, 30'h400 + 30'(b)));
      #1 check("ce_body_grant", in_grant, 4'b1000);
      tick();
      check("ce_credits", credits, 3 - b);
    end
    put(3, mk(BD, 30'h404));
    #1 check("ce_stall_grant", in_grant, 4'b0000);
    credit_in = 1'b1;
    #1 check("ce_same_cycle_credit", in_grant, 4'b0000);
    tick();
    credit_in = 1'b0;
    check("ce_credit_back", credits, 1);
    check("ce_stall_out_valid", out_valid, 0);
    #1 check("ce_resume_grant", in_grant, 4'b1000);
    tick();
    check("ce_resume_data", out_data, mk(BD, 30'h404));
    check("ce_resume_credits", credits, 0);
    put(3, mk(TL, 30'h405));
    #1 check("ce_tail_stall", in_grant, 4'b0000);
    credit_in = 1'b1;
    tick();
    credit_in = 1'b0;
    #1 check("ce_tail_grant", in_grant, 4'b1000);
    tick();
    check("ce_unlocked", locked, 0);
    check("ce_credits_end", credits, 0);
    in_valid = '0;
    credit_in = 1'b1;
    repeat (4) tick();
    credit_in = 1'b0;
    check("ce_refill", credits, 4);
    check("ce_refill_error", error, 0);

    // Protocol errors: stray body on E, then credit overflow
    put(2, mk(BD, 30'h500));
    #1 check("pe_no_grant", in_grant, 4'b0000);
    tick();
    check("pe_error_1", error, 1);
    tick();
    check("pe_error_2", error, 1);
    check("pe_out_valid", out_valid, 0);
    in_valid = '0;
    tick();
    check("pe_error_clear", error, 0);
    credit_in = 1'b1;
    tick();
    credit_in = 1'b0;
    check("pe_sat_error", error, 1);
    check("pe_sat_credits", credits, 4);
    tick();
    check("pe_sat_clear", error, 0);

    // Reset mid-packet on N (rr_ptr is 0 after W's tail)
    put(0, mk(HD, 30'h600));
    #1 check("rm_head_grant", in_grant, 4'b0001);
    tick();
    check("rm_locked", locked, 1);
    check("rm_owner", owner, 0);
    put(0, mk(BD, 30'h601));
    #1 check("rm_body_grant", in_grant, 4'b0001);
    tick();
    check("rm_credits_2", credits, 2);
    reset = 1'b1;
    put(0, mk(BD, 30'h602));
    #1 check("rm_grant_in_reset", in_grant, 4'b0000);
    tick();
    check("rm_unlocked", locked, 0);
    check("rm_credits", credits, 4);
    check("rm_out_valid", out_valid, 0);
    reset = 1'b0;
    #1 check("rm_refused", in_grant, 4'b0000);
    tick();
    check("rm_error", error, 1);
    check("rm_no_output", out_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
